apb_i2c_csr: RTL and testbench

APB_I2C_CSR -- requirements
Module: apb_i2c_csr

---
 rtl/apb_i2c_csr.sv | 166 ++++++++++++++++
 tb/tb_apb_i2c_csr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_csr.sv
// APB slave register block for an I2C core: TX/RX FIFO access with bounded
// wait states, CONFIG/TIMEOUT registers, and an edge-triggered interrupt block.
module apb_i2c_csr #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CFG_W    = 14,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
  output logic              WR_ENA,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  input  logic [DATA_W-1:0] READ_DATA_ON_RX,
  output logic              RD_ENA,
  input  logic              RX_EMPTY,
  input  logic              ERROR,
  output logic [CFG_W-1:0]  INTERNAL_I2C_REGISTER_CONFIG,
  output logic [CFG_W-1:0]  INTERNAL_I2C_REGISTER_TIMEOUT,
  output logic              IRQ
);

  localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int unsigned INT_W = 3;

  localparam logic [ADDR_W-1:0] A_TXDATA   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_RXDATA   = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_CONFIG   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_TIMEOUT  = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_INT_EN   = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_INT_STAT = ADDR_W'(8'h18);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [CFG_W-1:0]   config_q, config_d;
  logic [CFG_W-1:0]   timeout_q, timeout_d;
  logic [INT_W-1:0]   int_en_q, int_en_d;
  logic [INT_W-1:0]   int_stat_q, int_stat_d;
  logic [INT_W-1:0]   edge_q, edge_d;
  logic               tx_empty_h_q, rx_empty_h_q, error_h_q;

  logic               acc, need_wait, timeout, dec_err, mapped;
  logic               hit_tx, hit_rx, hit_cfg, hit_tmo, hit_st, hit_ien, hit_ist;
  logic               pready_c, pslverr_c, wr_ok, rd_ok;
  logic [INT_W-1:0]   w1c_mask;
  logic [DATA_W-1:0]  prdata_c;

  // Address decode, wait/error resolution, register next-state and APB FSM.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    config_d   = config_q;
    timeout_d  = timeout_q;
    int_en_d   = int_en_q;
    w1c_mask   = '0;
    prdata_c   = '0;

    hit_tx  = (PADDR == A_TXDATA);
    hit_rx  = (PADDR == A_RXDATA);
    hit_cfg = (PADDR == A_CONFIG);
    hit_tmo = (PADDR == A_TIMEOUT);
    hit_st  = (PADDR == A_STATUS);
    hit_ien = (PADDR == A_INT_EN);
    hit_ist = (PADDR == A_INT_STAT);
    mapped  = hit_tx | hit_rx | hit_cfg | hit_tmo | hit_st | hit_ien | hit_ist;

    acc       = PRESETn && (state_q == ACCESS) && PSELx && PENABLE;
    need_wait = (hit_tx && PWRITE && TX_FULL) || (hit_rx && !PWRITE && RX_EMPTY);
    timeout   = need_wait && (wait_q == CNT_W'(WAIT_MAX));
    dec_err   = !mapped || (PWRITE && (hit_rx || hit_st)) || (!PWRITE && hit_tx);
    pready_c  = acc && (!need_wait || timeout);
    pslverr_c = pready_c && (dec_err || timeout);
    wr_ok     = pready_c && !pslverr_c && PWRITE;
    rd_ok     = pready_c && !pslverr_c && !PWRITE;

    // Stalled FIFO access counts wait states; anything else restarts from zero.
    if (acc && need_wait && !timeout) begin
      wait_d = wait_q + CNT_W'(1);
    end

    if (wr_ok) begin
      if (hit_cfg) config_d  = PWDATA[CFG_W-1:0];
      if (hit_tmo) timeout_d = PWDATA[CFG_W-1:0];
      if (hit_ien) int_en_d  = PWDATA[INT_W-1:0];
      if (hit_ist) w1c_mask  = PWDATA[INT_W-1:0];
    end

    if (rd_ok) begin
      if (hit_rx)  prdata_c = READ_DATA_ON_RX;
      if (hit_cfg) prdata_c = DATA_W'(config_q);
      if (hit_tmo) prdata_c = DATA_W'(timeout_q);
      if (hit_st)  prdata_c = DATA_W'({ERROR, RX_EMPTY, TX_FULL, TX_EMPTY});
      if (hit_ien) prdata_c = DATA_W'(int_en_q);
      if (hit_ist) prdata_c = DATA_W'(int_stat_q);
    end

    // A new edge in the same cycle as its W1C wins, so the event is not lost.
    int_stat_d = (int_stat_q & ~w1c_mask) | edge_q;
    edge_d     = {ERROR & ~error_h_q, ~RX_EMPTY & rx_empty_h_q, TX_EMPTY & ~tx_empty_h_q};

    case (state_q)
      IDLE:    if (PSELx && !PENABLE) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (!PSELx)          state_d = IDLE;
        else if (!PENABLE)   state_d = SETUP;
        else if (pready_c)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      config_q     <= '0;
      timeout_q    <= '0;
      int_en_q     <= '0;
      int_stat_q   <= '0;
      edge_q       <= '0;
      tx_empty_h_q <= 1'b1;
      rx_empty_h_q <= 1'b1;
      error_h_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      config_q     <= config_d;
      timeout_q    <= timeout_d;
      int_en_q     <= int_en_d;
      int_stat_q   <= int_stat_d;
      edge_q       <= edge_d;
      tx_empty_h_q <= TX_EMPTY;
      rx_empty_h_q <= RX_EMPTY;
      error_h_q    <= ERROR;
    end
  end

  assign PREADY                        = pready_c;
  assign PSLVERR                       = pslverr_c;
  assign PRDATA                        = prdata_c;
  assign WR_ENA                        = wr_ok && hit_tx;
  assign RD_ENA                        = rd_ok && hit_rx;
  assign WRITE_DATA_ON_TX              = (wr_ok && hit_tx) ? PWDATA : '0;
  assign INTERNAL_I2C_REGISTER_CONFIG  = config_q;
  assign INTERNAL_I2C_REGISTER_TIMEOUT = timeout_q;
  assign IRQ                           = PRESETn && |(int_stat_q & int_en_q);

endmodule

// File: tb/tb_apb_i2c_csr.sv
// Directed self-checking bench for apb_i2c_csr.
module tb_apb_i2c_csr;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] WRITE_DATA_ON_TX;
  logic        WR_ENA, RD_ENA, IRQ;
  logic        TX_FULL = 1'b0, TX_EMPTY = 1'b1, RX_EMPTY = 1'b1, ERROR = 1'b0;
  logic [31:0] READ_DATA_ON_RX = '0;
  logic [13:0] CFG_O, TMO_O;

  int checks = 0;
  int passed = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  apb_i2c_csr dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX),
    .WR_ENA(WR_ENA), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .READ_DATA_ON_RX(READ_DATA_ON_RX), .RD_ENA(RD_ENA), .RX_EMPTY(RX_EMPTY),
    .ERROR(ERROR), .INTERNAL_I2C_REGISTER_CONFIG(CFG_O),
    .INTERNAL_I2C_REGISTER_TIMEOUT(TMO_O), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  // Count FIFO strobes mid-cycle.
  always @(negedge PCLK) begin
    if (WR_ENA) wr_cnt++;
    if (RD_ENA) rd_cnt++;
  end

  // One APB transfer; waits counts sampled not-ready cycles after PENABLE rises
  // (the first is the SETUP-state cycle). release_at drops TX_FULL at that count.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input int release_at, output logic [31:0] rdata, output logic err,
                          output logic [31:0] txd, output int waits);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; rdata = '0; err = 1'b0; txd = '0;
    for (int i = 0; i <= 40; i++) begin
      if (release_at > 0 && waits == release_at) TX_FULL = 1'b0;
      #1;
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; txd = WRITE_DATA_ON_TX;
        break;
      end
      waits++;
      if (i == 40) $display("FAIL xfer_timeout addr=%h: no PREADY within bound", addr);
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'hFFFF_FFFF;
    repeat (3) @(posedge PCLK);
    #1;
    checks++; if ({PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ} !== 5'b0) $display("FAIL reset_ctl: got %b expected 00000", {PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ}); else passed++;
    checks++; if (PRDATA !== 32'h0) $display("FAIL reset_prdata: got %h expected 0", PRDATA); else passed++;
    checks++; if ({CFG_O, TMO_O} !== 28'h0) $display("FAIL reset_regs: got %h expected 0", {CFG_O, TMO_O}); else passed++;
    PSELx = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
    #1;
    checks++; if ({PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ} !== 5'b0) $display("FAIL post_reset_ctl: got %b expected 00000", {PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ}); else passed++;
    @(posedge PCLK); #1;
  endtask

  task automatic test_config();
    logic [31:0] rd, txd; logic err; int w;
    apb_xfer(1'b1, 8'h08, 32'h0000_3ABC, 0, rd, err, txd, w);
    checks++; if (w !== 1 || err !== 1'b0) $display("FAIL cfg_write: got waits=%0d err=%b expected waits=1 err=0", w, err); else passed++;
    checks++; if (CFG_O !== 14'h3ABC) $display("FAIL cfg_out: got %h expected 3abc", CFG_O); else passed++;
    apb_xfer(1'b0, 8'h08, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h0000_3ABC || err !== 1'b0) $display("FAIL cfg_read: got %h err=%b expected 00003abc err=0", rd, err); else passed++;
    apb_xfer(1'b1, 8'h0C, 32'hFFFF_FFFF, 0, rd, err, txd, w);
    checks++; if (TMO_O !== 14'h3FFF) $display("FAIL tmo_out: got %h expected 3fff", TMO_O); else passed++;
    apb_xfer(1'b0, 8'h0C, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h0000_3FFF) $display("FAIL tmo_read: got %h expected 00003fff", rd); else passed++;
  endtask

  task automatic test_tx_wait();
    logic [31:0] rd, txd; logic err; int w, w0;
    w0 = wr_cnt;
    TX_FULL = 1'b1;
    apb_xfer(1'b1, 8'h00, 32'hDEAD_BEEF, 4, rd, err, txd, w);
    checks++; if (w !== 4 || err !== 1'b0) $display("FAIL tx_wait: got waits=%0d err=%b expected waits=4 err=0", w, err); else passed++;
    checks++; if (txd !== 32'hDEAD_BEEF) $display("FAIL tx_data: got %h expected deadbeef", txd); else passed++;
    checks++; if (wr_cnt - w0 !== 1) $display("FAIL tx_pulses: got %0d expected 1", wr_cnt - w0); else passed++;
  endtask

  task automatic test_rx_read();
    logic [31:0] rd, txd; logic err; int w, r0;
    r0 = rd_cnt;
    RX_EMPTY = 1'b0; READ_DATA_ON_RX = 32'hCAFE_F00D;
    apb_xfer(1'b0, 8'h04, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'hCAFE_F00D || err !== 1'b0 || w !== 1) $display("FAIL rx_read: got %h err=%b waits=%0d expected cafef00d err=0 waits=1", rd, err, w); else passed++;
    checks++; if (rd_cnt - r0 !== 1) $display("FAIL rx_pulses: got %0d expected 1", rd_cnt - r0); else passed++;
    RX_EMPTY = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_rx_timeout();
    logic [31:0] rd, txd; logic err; int w, r0;
    r0 = rd_cnt;
    apb_xfer(1'b0, 8'h04, 32'h0, 0, rd, err, txd, w);
    checks++; if (w !== 16 || err !== 1'b1) $display("FAIL rx_timeout: got waits=%0d err=%b expected waits=16 err=1", w, err); else passed++;
    checks++; if (rd !== 32'h0 || rd_cnt - r0 !== 0) $display("FAIL rx_timeout_side: got rd=%h pulses=%0d expected 0 0", rd, rd_cnt - r0); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd, txd; logic err; int w, r0;
    r0 = rd_cnt;
    apb_xfer(1'b0, 8'h10, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h5 || err !== 1'b0) $display("FAIL status_read: got %h err=%b expected 00000005 err=0", rd, err); else passed++;
    apb_xfer(1'b0, 8'h1C, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h0 || err !== 1'b1 || w !== 1) $display("FAIL unmapped_read: got %h err=%b waits=%0d expected 0 err=1 waits=1", rd, err, w); else passed++;
    apb_xfer(1'b1, 8'h10, 32'hFFFF_FFFF, 0, rd, err, txd, w);
    checks++; if (err !== 1'b1) $display("FAIL status_write_err: got %b expected 1", err); else passed++;
    apb_xfer(1'b0, 8'h10, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h5) $display("FAIL status_unchanged: got %h expected 00000005", rd); else passed++;
    apb_xfer(1'b0, 8'h00, 32'h0, 0, rd, err, txd, w);
    checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL txdata_read: got err=%b rd=%h expected err=1 rd=0", err, rd); else passed++;
    apb_xfer(1'b1, 8'h04, 32'h1234_5678, 0, rd, err, txd, w);
    checks++; if (err !== 1'b1 || rd_cnt - r0 !== 0) $display("FAIL rxdata_write: got err=%b pulses=%0d expected err=1 pulses=0", err, rd_cnt - r0); else passed++;
    apb_xfer(1'b1, 8'h09, 32'h0000_0001, 0, rd, err, txd, w);
    checks++; if (err !== 1'b1 || CFG_O !== 14'h3ABC) $display("FAIL unaligned_write: got err=%b cfg=%h expected err=1 cfg=3abc", err, CFG_O); else passed++;
  endtask

  task automatic test_interrupts();
    logic [31:0] rd, txd; logic err; int w;
    apb_xfer(1'b0, 8'h18, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h2 || IRQ !== 1'b0) $display("FAIL int_rx_edge: got stat=%h irq=%b expected 00000002 irq=0", rd, IRQ); else passed++;
    apb_xfer(1'b1, 8'h18, 32'h7, 0, rd, err, txd, w);
    apb_xfer(1'b0, 8'h18, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h0) $display("FAIL int_w1c_all: got %h expected 0", rd); else passed++;
    apb_xfer(1'b1, 8'h14, 32'hFC, 0, rd, err, txd, w);
    apb_xfer(1'b0, 8'h14, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h4) $display("FAIL int_en_read: got %h expected 00000004", rd); else passed++;
    ERROR = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    checks++; if (IRQ !== 1'b1) $display("FAIL irq_on_error: got %b expected 1", IRQ); else passed++;
    apb_xfer(1'b0, 8'h18, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h4) $display("FAIL int_err_edge: got %h expected 00000004", rd); else passed++;
    ERROR = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    // W1C lands in the same cycle the new ERROR edge sets the bit.
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h18; PWDATA = 32'h4;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; ERROR = 1'b1;
    @(posedge PCLK); #2;
    checks++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0) $display("FAIL w1c_collide_ready: got rdy=%b err=%b expected 1 0", PREADY, PSLVERR); else passed++;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    apb_xfer(1'b0, 8'h18, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h4 || IRQ !== 1'b1) $display("FAIL w1c_collide: got stat=%h irq=%b expected 00000004 irq=1", rd, IRQ); else passed++;
    apb_xfer(1'b1, 8'h18, 32'h4, 0, rd, err, txd, w);
    apb_xfer(1'b0, 8'h18, 32'h0, 0, rd, err, txd, w);
    checks++; if (rd !== 32'h0 || IRQ !== 1'b0) $display("FAIL w1c_plain: got stat=%h irq=%b expected 0 irq=0", rd, IRQ); else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] rd, txd; logic err; int w, w0;
    w0 = wr_cnt;
    TX_FULL = 1'b1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hAAAA_5555;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    TX_FULL = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    checks++; if (wr_cnt - w0 !== 0) $display("FAIL abort_no_push: got %0d expected 0", wr_cnt - w0); else passed++;
    apb_xfer(1'b1, 8'h00, 32'h1234_5678, 0, rd, err, txd, w);
    checks++; if (w !== 1 || err !== 1'b0 || txd !== 32'h1234_5678 || wr_cnt - w0 !== 1) $display("FAIL after_abort: got waits=%0d err=%b txd=%h pushes=%0d expected 1 0 12345678 1", w, err, txd, wr_cnt - w0); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, txd; logic err; int w, w0;
    apb_xfer(1'b1, 8'h08, 32'h155, 0, rd, err, txd, w);
    checks++; if (CFG_O !== 14'h155) $display("FAIL pre_reset_cfg: got %h expected 0155", CFG_O); else passed++;
    w0 = wr_cnt;
    TX_FULL = 1'b1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h1111_1111;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    checks++; if (PREADY !== 1'b0) $display("FAIL mid_wait: got %b expected 0", PREADY); else passed++;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    TX_FULL = 1'b0;
    #1;
    checks++; if ({PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ} !== 5'b0 || PRDATA !== 32'h0) $display("FAIL reset_mid_outs: got %b prdata=%h expected 00000 0", {PREADY, PSLVERR, WR_ENA, RD_ENA, IRQ}, PRDATA); else passed++;
    checks++; if (CFG_O !== 14'h0 || TMO_O !== 14'h0) $display("FAIL reset_mid_regs: got cfg=%h tmo=%h expected 0 0", CFG_O, TMO_O); else passed++;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
    #1;
    checks++; if (PREADY !== 1'b0 || wr_cnt - w0 !== 0) $display("FAIL reset_mid_push: got rdy=%b pushes=%0d expected 0 0", PREADY, wr_cnt - w0); else passed++;
    @(posedge PCLK); #1;
  endtask

  initial begin
    test_reset();
    test_config();
    test_tx_wait();
    test_rx_read();
    test_rx_timeout();
    test_errors();
    test_interrupts();
    test_abort();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
